hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Producer side of the bypass network: decides when operands cannot be forwarded and the
//  pipeline must stall, bubble or flush. Sits in decode; drives PC/IF-ID write enables,
//  the ID-EX bubble select and IF-ID/ID-EX flushes. Also handles data-memory wait states,
//  taken-branch squash, HALT freeze, a memory-wait watchdog and a stall-cycle counter.
// PARAMETERS
//  REG_W        3   register-specifier width
//  CNT_W        16  stall-cycle counter width
//  WDOG_CYC     64  max consecutive mem_busy cycles before mem_timeout
// PORTS
//  clk            in   1      clock, all state on rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  IFID_Rs        in   REG_W  source A of instr in decode
//  IFID_Rt        in   REG_W  source B of instr in decode
//  IFID_rdRs      in   1      decode instr actually reads Rs
//  IFID_rdRt      in   1      decode instr actually reads Rt
//  IDEX_Rd        in   REG_W  destination of instr in execute
//  IDEX_MemRead   in   1      execute instr is a load
//  IDEX_RegWrite  in   1      execute instr writes a register
//  mem_busy       in   1      data memory not ready this cycle
//  br_taken       in   1      execute resolved a taken branch/jump (1-cycle pulse)
//  halt_dec       in   1      HALT reached writeback
//  PC_we          out  1      PC may update
//  IFID_we        out  1      IF-ID register may update
//  IDEX_bubble    out  1      load NOP control into ID-EX
//  IFID_flush     out  1      squash IF-ID contents
//  MEM_freeze     out  1      hold EX-MEM and MEM-WB
//  mem_timeout    out  1      sticky watchdog error
//  stall_cycles   out  CNT_W  count of cycles with PC_we==0 (excluding HALTED)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=RUN, PC_we=0, IFID_we=0, IDEX_bubble=1, IFID_flush=0,
//   MEM_freeze=0, mem_timeout=0, stall_cycles=0, pend_flush=0, wdog=0.
//  lu_haz = IDEX_MemRead & IDEX_RegWrite & ((IFID_rdRs & IDEX_Rd==IFID_Rs) |
//   (IFID_rdRt & IDEX_Rd==IFID_Rt)). Outputs are combinational from state+inputs (0 latency).
//  States: RUN, MEM_WAIT, FLUSH, HALTED. Priority per cycle: halt > mem_busy > br_taken > lu_haz.
//  RUN: mem_busy -> all enables 0, MEM_FREEZE=1, go MEM_WAIT; br_taken -> IFID_flush=1,
//   IDEX_bubble=1, PC_we=1 (loads target), IFID_we=1, go FLUSH; lu_haz -> PC_we=0, IFID_we=0,
//   IDEX_bubble=1, stay RUN (bubble clears hazard next cycle); else PC_we=IFID_we=1, others 0.
//  MEM_WAIT: PC_we=IFID_we=0, MEM_freeze=1, IDEX_bubble=0 (ID-EX held). br_taken seen here sets
//   pend_flush. On mem_busy=0: if pend_flush go FLUSH (clear pend_flush) else RUN.
//  FLUSH: exactly 1 cycle; IFID_flush=1, IDEX_bubble=1, PC_we=IFID_we=1; then RUN. lu_haz ignored.
//  HALTED: entered from any state when halt_dec=1; PC_we=IFID_we=0, IDEX_bubble=1, MEM_freeze=0;
//   exits only by reset.
//  Watchdog: wdog counts consecutive mem_busy cycles, clears when mem_busy=0; at WDOG_CYC sets
//   mem_timeout (sticky until reset), wdog saturates; state machine unaffected.
//  stall_cycles: +1 each cycle PC_we==0 and state!=HALTED; saturates at all-ones, no wrap.
//  Reset mid-MEM_WAIT/FLUSH: immediate return to reset values, pending flush discarded.
//  Register 0 is not special: Rd==0 hazard still stalls.
// TESTING
//  T1 load r3 in EX, decode reads Rs=3 -> one cycle PC_we=0,IFID_we=0,IDEX_bubble=1; stall_cycles=1.
//  T2 same but IFID_rdRs=0, Rt=3 rdRt=0 -> no stall, PC_we=1 throughout.
//  T3 mem_busy 3 cycles -> MEM_WAIT 3 cycles, MEM_freeze=1, stall_cycles=3, back to RUN.
//  T4 br_taken during MEM_WAIT -> FLUSH one cycle after mem_busy drops, IFID_flush=1 once.
//  T5 mem_busy held 64 cycles (WDOG_CYC=64) -> mem_timeout=1 on 64th, stays 1 after release.
//  T6 halt_dec=1 while lu_haz -> HALTED, PC_we=0 forever; rst_n low mid-op -> reset values at once.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage stall/flush controller: load-use interlock, data-memory wait states,
// taken-branch squash, HALT freeze, memory-wait watchdog and stall-cycle statistics.
module hazard_stall_ctrl #(
  parameter int REG_W    = 3,
  parameter int CNT_W    = 16,
  parameter int WDOG_CYC = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] IFID_Rs,
  input  logic [REG_W-1:0] IFID_Rt,
  input  logic             IFID_rdRs,
  input  logic             IFID_rdRt,
  input  logic [REG_W-1:0] IDEX_Rd,
  input  logic             IDEX_MemRead,
  input  logic             IDEX_RegWrite,
  input  logic             mem_busy,
  input  logic             br_taken,
  input  logic             halt_dec,
  output logic             PC_we,
  output logic             IFID_we,
  output logic             IDEX_bubble,
  output logic             IFID_flush,
  output logic             MEM_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WD_W = $clog2(WDOG_CYC + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2,
    S_HALTED   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               pend_flush_q, pend_flush_d;
  logic [WD_W-1:0]    wdog_q, wdog_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  logic lu_haz_s, wdog_hit_s;
  logic pc_we_s, ifid_we_s, idex_bubble_s, ifid_flush_s, mem_freeze_s;

  assign lu_haz_s = IDEX_MemRead & IDEX_RegWrite &
                    ((IFID_rdRs & (IDEX_Rd == IFID_Rs)) |
                     (IFID_rdRt & (IDEX_Rd == IFID_Rt)));

  // Next state and zero-latency pipeline controls; priority halt > mem_busy > br_taken > lu_haz.
  always_comb begin
    state_d       = state_q;
    pend_flush_d  = pend_flush_q;
    pc_we_s       = 1'b0;
    ifid_we_s     = 1'b0;
    idex_bubble_s = 1'b0;
    ifid_flush_s  = 1'b0;
    mem_freeze_s  = 1'b0;
    if (halt_dec) begin
      state_d       = S_HALTED;
      pend_flush_d  = 1'b0;
      idex_bubble_s = 1'b1;
    end else begin
      case (state_q)
        S_RUN: begin
          if (mem_busy) begin
            mem_freeze_s = 1'b1;
            pend_flush_d = br_taken;
            state_d      = S_MEM_WAIT;
          end else if (br_taken) begin
            pc_we_s       = 1'b1;
            ifid_we_s     = 1'b1;
            idex_bubble_s = 1'b1;
            ifid_flush_s  = 1'b1;
            state_d       = S_FLUSH;
          end else if (lu_haz_s) begin
            idex_bubble_s = 1'b1;
          end else begin
            pc_we_s   = 1'b1;
            ifid_we_s = 1'b1;
          end
        end
        S_MEM_WAIT: begin
          if (mem_busy) begin
            mem_freeze_s = 1'b1;
            pend_flush_d = pend_flush_q | br_taken;
          end else if (pend_flush_q | br_taken) begin
            // Memory done but a squash is owed: keep the wrong-path decode instr out of EX.
            idex_bubble_s = 1'b1;
            pend_flush_d  = 1'b0;
            state_d       = S_FLUSH;
          end else if (lu_haz_s) begin
            idex_bubble_s = 1'b1;
            state_d       = S_RUN;
          end else begin
            pc_we_s   = 1'b1;
            ifid_we_s = 1'b1;
            state_d   = S_RUN;
          end
        end
        S_FLUSH: begin
          if (mem_busy) begin
            mem_freeze_s = 1'b1;
            pend_flush_d = 1'b1;
            state_d      = S_MEM_WAIT;
          end else begin
            pc_we_s       = 1'b1;
            ifid_we_s     = 1'b1;
            idex_bubble_s = 1'b1;
            ifid_flush_s  = 1'b1;
            state_d       = S_RUN;
          end
        end
        S_HALTED: begin
          idex_bubble_s = 1'b1;
        end
        default: begin
          idex_bubble_s = 1'b1;
          state_d       = S_RUN;
        end
      endcase
    end
  end

  // Watchdog on consecutive busy cycles and saturating stall statistics.
  always_comb begin
    wdog_hit_s = mem_busy && (wdog_q == WD_W'(WDOG_CYC - 1));
    if (!mem_busy) begin
      wdog_d = {WD_W{1'b0}};
    end else if (wdog_q != WD_W'(WDOG_CYC)) begin
      wdog_d = wdog_q + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      wdog_d = wdog_q;
    end
    mem_timeout_d = mem_timeout_q | wdog_hit_s;
    if (!pc_we_s && (state_q != S_HALTED) && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Output stage: reset forces the safe pipeline-hold values while rst_n is low.
  always_comb begin
    if (!rst_n) begin
      PC_we       = 1'b0;
      IFID_we     = 1'b0;
      IDEX_bubble = 1'b1;
      IFID_flush  = 1'b0;
      MEM_freeze  = 1'b0;
      mem_timeout = 1'b0;
    end else begin
      PC_we       = pc_we_s;
      IFID_we     = ifid_we_s;
      IDEX_bubble = idex_bubble_s;
      IFID_flush  = ifid_flush_s;
      MEM_freeze  = mem_freeze_s;
      mem_timeout = mem_timeout_q | wdog_hit_s;
    end
  end

  assign stall_cycles = stall_cycles_q;

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_RUN;
      pend_flush_q   <= 1'b0;
      wdog_q         <= {WD_W{1'b0}};
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      pend_flush_q   <= pend_flush_d;
      wdog_q         <= wdog_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl; outputs sampled on the falling edge.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  IFID_Rs, IFID_Rt, IDEX_Rd;
  logic        IFID_rdRs, IFID_rdRt, IDEX_MemRead, IDEX_RegWrite;
  logic        mem_busy, br_taken, halt_dec;
  logic        PC_we, IFID_we, IDEX_bubble, IFID_flush, MEM_freeze, mem_timeout;
  logic [15:0] stall_cycles;
  logic [4:0]  outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign outs = {PC_we, IFID_we, IDEX_bubble, IFID_flush, MEM_freeze};

  hazard_stall_ctrl #(.REG_W(3), .CNT_W(16), .WDOG_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_rdRs(IFID_rdRs), .IFID_rdRt(IFID_rdRt),
    .IDEX_Rd(IDEX_Rd), .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
    .mem_busy(mem_busy), .br_taken(br_taken), .halt_dec(halt_dec),
    .PC_we(PC_we), .IFID_we(IFID_we), .IDEX_bubble(IDEX_bubble), .IFID_flush(IFID_flush),
    .MEM_freeze(MEM_freeze), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  task automatic idle_inputs();
    IFID_Rs = 3'd1; IFID_Rt = 3'd2; IDEX_Rd = 3'd7;
    IFID_rdRs = 1'b0; IFID_rdRt = 1'b0; IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0;
    mem_busy = 1'b0; br_taken = 1'b0; halt_dec = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 5'b00100) begin errors++; $display("FAIL reset_outs got %b exp %b", outs, 5'b00100); end
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", mem_timeout); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL post_reset_run got %b exp %b", outs, 5'b11000); end
  endtask

  task automatic test_load_use();
    do_reset();
    IDEX_Rd = 3'd3; IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1;
    IFID_Rs = 3'd3; IFID_rdRs = 1'b1; IFID_Rt = 3'd5; IFID_rdRt = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b00100) begin errors++; $display("FAIL lu_stall got %b exp %b", outs, 5'b00100); end
    next_cycle();
    IDEX_MemRead = 1'b0; IDEX_RegWrite = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL lu_resume got %b exp %b", outs, 5'b11000); end
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", stall_cycles); end
    next_cycle();
    // destination r0 still interlocks, via the Rt port
    IDEX_Rd = 3'd0; IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1;
    IFID_Rs = 3'd2; IFID_rdRs = 1'b1; IFID_Rt = 3'd0; IFID_rdRt = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b00100) begin errors++; $display("FAIL lu_r0 got %b exp %b", outs, 5'b00100); end
    next_cycle();
    IDEX_RegWrite = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL lu_nowrite got %b exp %b", outs, 5'b11000); end
    checks++; if (stall_cycles !== 16'd2) begin errors++; $display("FAIL lu_count2 got %0d exp 2", stall_cycles); end
  endtask

  task automatic test_no_read();
    do_reset();
    IDEX_Rd = 3'd3; IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1;
    IFID_Rs = 3'd3; IFID_rdRs = 1'b0; IFID_Rt = 3'd3; IFID_rdRt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL noread_run%0d got %b exp %b", i, outs, 5'b11000); end
      next_cycle();
    end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL noread_count got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (outs !== 5'b00001) begin errors++; $display("FAIL memwait_%0d got %b exp %b", i, outs, 5'b00001); end
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL memwait_release got %b exp %b", outs, 5'b11000); end
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL memwait_count got %0d exp 3", stall_cycles); end
    next_cycle();
    @(negedge clk);
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL memwait_run got %b exp %b", outs, 5'b11000); end
  endtask

  task automatic test_branch_in_wait();
    logic [4:0] exp_tab [0:8];
    logic       busy_tab [0:8];
    logic       br_tab [0:8];
    int         nflush;
    exp_tab = '{5'b00001, 5'b00001, 5'b00001, 5'b00100, 5'b11110, 5'b11000,
                5'b11110, 5'b11110, 5'b11000};
    busy_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    br_tab   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    nflush = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      mem_busy = busy_tab[i];
      br_taken = br_tab[i];
      @(negedge clk);
      if (i < 6 && IFID_flush === 1'b1) nflush++;
      checks++; if (outs !== exp_tab[i]) begin errors++; $display("FAIL branch_c%0d got %b exp %b", i, outs, exp_tab[i]); end
      next_cycle();
    end
    checks++; if (nflush !== 1) begin errors++; $display("FAIL branch_flush_once got %0d exp 1", nflush); end
  endtask

  task automatic test_watchdog();
    do_reset();
    mem_busy = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 63) begin
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL wdog_63 got %b exp 0", mem_timeout); end
      end
      if (k == 64) begin
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL wdog_64 got %b exp 1", mem_timeout); end
        checks++; if (outs !== 5'b00001) begin errors++; $display("FAIL wdog_fsm got %b exp %b", outs, 5'b00001); end
      end
      next_cycle();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    checks++; if (stall_cycles !== 16'd64) begin errors++; $display("FAIL wdog_count got %0d exp 64", stall_cycles); end
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b exp 1", mem_timeout); end
    checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL wdog_run got %b exp %b", outs, 5'b11000); end
  endtask

  task automatic test_halt_and_reset();
    do_reset();
    IDEX_Rd = 3'd4; IDEX_MemRead = 1'b1; IDEX_RegWrite = 1'b1;
    IFID_Rs = 3'd4; IFID_rdRs = 1'b1; halt_dec = 1'b1;
    @(negedge clk);
    checks++; if (outs !== 5'b00100) begin errors++; $display("FAIL halt_entry got %b exp %b", outs, 5'b00100); end
    next_cycle();
    idle_inputs();
    mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin mem_busy = 1'b0; br_taken = 1'b1; end
      @(negedge clk);
      checks++; if (outs !== 5'b00100) begin errors++; $display("FAIL halted_%0d got %b exp %b", i, outs, 5'b00100); end
      next_cycle();
    end
    checks++; if (stall_cycles !== 16'd1) begin errors++; $display("FAIL halt_count got %0d exp 1", stall_cycles); end
    // park in MEM_WAIT with a pending flush, then reset mid-cycle
    do_reset();
    mem_busy = 1'b1; br_taken = 1'b1;
    next_cycle();
    br_taken = 1'b0;
    next_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (outs !== 5'b00100) begin errors++; $display("FAIL async_reset got %b exp %b", outs, 5'b00100); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL async_reset_count got %0d exp 0", stall_cycles); end
    idle_inputs();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (outs !== 5'b11000) begin errors++; $display("FAIL no_stale_flush%0d got %b exp %b", i, outs, 5'b11000); end
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_read();
    test_mem_wait();
    test_branch_in_wait();
    test_watchdog();
    test_halt_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
